// File: rtl/cmd_server_pkg.sv
// Shared constants and FSM state encoding for the UART command server.
package cmd_server_pkg;

   localparam logic [7:0] HDR_WR = 8'h5A;
   localparam logic [7:0] HDR_RD = 8'h5B;
   localparam logic [7:0] TRL_WR = 8'hA5;
   localparam logic [7:0] TRL_RD = 8'hA4;

   localparam int FRAME_LEN       = 10;
   localparam int BODY_LEN        = 8;
   localparam int TIMEOUT_TICKS   = 2;
   localparam int UART_FRAME_BITS = 10;

   typedef enum logic [2:0] {
      HUNT,
      RX_BODY,
      RX_TRAIL,
      BUS,
      BUS_WAIT,
      TX_RESP
   } state_t;

   function automatic logic is_header(input logic [7:0] b);
      return (b == HDR_WR) || (b == HDR_RD);
   endfunction

   function automatic logic [7:0] trailer_of(input logic [7:0] hdr);
      return (hdr == HDR_WR) ? TRL_WR : TRL_RD;
   endfunction

endpackage

// File: rtl/cmd_server_uart.sv
// Byte-level 8N1 UART: RX with mid-bit sampling and start recheck, TX with
// a valid/ready handshake that accepts the next byte during the stop bit.
module cmd_uart
   import cmd_server_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 100000000,
   parameter int BAUD_RATE   = 115200
) (
   input  logic       clk_sys,
   input  logic       rst_b,
   input  logic       rxd,
   output logic       txd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready
);

   localparam int BIT_CLKS  = CLK_FREQ_HZ / BAUD_RATE;
   localparam int HALF_CLKS = BIT_CLKS / 2;
   localparam int CW        = $clog2(BIT_CLKS);
   localparam logic [3:0] LAST_BIT = 4'(UART_FRAME_BITS - 1);

   logic [1:0]    rx_sync;
   logic          rx_s;
   logic          rx_prev;
   logic          rx_busy;
   logic [CW-1:0] rx_cnt;
   logic [3:0]    rx_bit;
   logic [7:0]    rx_shift;

   assign rx_s    = rx_sync[1];
   assign rx_data = rx_shift;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         rx_sync  <= 2'b11;
         rx_prev  <= 1'b1;
         rx_busy  <= 1'b0;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_sync  <= {rx_sync[0], rxd};
         rx_prev  <= rx_s;
         rx_valid <= 1'b0;
         if (!rx_busy) begin
            if (rx_prev && !rx_s) begin
               rx_busy <= 1'b1;
               rx_cnt  <= CW'(HALF_CLKS - 1);
               rx_bit  <= '0;
            end
         end else if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - CW'(1);
         end else begin
            rx_cnt <= CW'(BIT_CLKS - 1);
            rx_bit <= rx_bit + 4'd1;
            if (rx_bit == 4'd0) begin
               if (rx_s) rx_busy <= 1'b0;   // glitch, not a real start bit
            end else if (rx_bit == LAST_BIT) begin
               rx_busy  <= 1'b0;
               rx_valid <= rx_s;            // framing error drops the byte
            end else begin
               rx_shift <= {rx_s, rx_shift[7:1]};
            end
         end
      end
   end

   logic          tx_busy;
   logic          tx_last;
   logic [CW-1:0] tx_cnt;
   logic [3:0]    tx_bit;
   logic [9:0]    tx_shift;

   assign tx_last  = tx_busy && (tx_cnt == '0) && (tx_bit == LAST_BIT);
   assign tx_ready = !tx_busy || tx_last;
   assign txd      = tx_shift[0];

   // Idle shift register is all ones, so txd idles high without a mux.
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         tx_busy  <= 1'b0;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '1;
      end else if (tx_valid && tx_ready) begin
         tx_busy  <= 1'b1;
         tx_cnt   <= CW'(BIT_CLKS - 1);
         tx_bit   <= '0;
         tx_shift <= {1'b1, tx_data, 1'b0};
      end else if (tx_busy) begin
         if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - CW'(1);
         end else if (tx_last) begin
            tx_busy <= 1'b0;
         end else begin
            tx_cnt   <= CW'(BIT_CLKS - 1);
            tx_bit   <= tx_bit + 4'd1;
            tx_shift <= {1'b1, tx_shift[9:1]};
         end
      end
   end

endmodule

// File: rtl/cmd_server.sv
// UART command server: parses 10-byte frames into single OPB reads/writes
// and returns a 10-byte response.
//
// state    | meaning
// HUNT     | waiting for a 0x5A/0x5B header byte
// RX_BODY  | collecting 4 address + 4 data bytes
// RX_TRAIL | waiting for the trailer (inverse of header)
// BUS      | one-cycle OPB_WE or OPB_RE strobe
// BUS_WAIT | read data captured, response assembled
// TX_RESP  | sending the 10 response bytes
module cmd_server
   import cmd_server_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 100000000,
   parameter int BAUD_RATE   = 115200
) (
   input  logic        SYS_CLK,
   input  logic        SYS_RST,
   input  logic        PULSE_2KHZ,
   output logic        OPB_CLK,
   output logic        OPB_RST,
   input  logic [31:0] OPB_DI,
   output logic [31:0] OPB_DO,
   output logic [31:0] OPB_ADDR,
   output logic        OPB_RE,
   output logic        OPB_WE,
   input  logic        UART_RXD,
   output logic        UART_TXD
);

   localparam int TW = $clog2(TIMEOUT_TICKS + 1);

   state_t        state, state_nxt;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          tx_valid;
   logic          tx_ready;
   logic [7:0]    hdr;
   logic [63:0]   body;
   logic [3:0]    byte_cnt;
   logic [TW-1:0] to_cnt;
   logic [2:0]    pulse_sync;
   logic          pulse_rise;
   logic          timeout;
   logic          trail_ok;
   logic [79:0]   tx_buf;
   logic [3:0]    tx_left;

   assign OPB_CLK    = SYS_CLK;
   assign OPB_RST    = ~SYS_RST;
   assign pulse_rise = pulse_sync[1] & ~pulse_sync[2];
   assign timeout    = pulse_rise && !rx_valid && (to_cnt == TW'(1));
   assign trail_ok   = (rx_data == trailer_of(hdr));

   cmd_uart #(
      .CLK_FREQ_HZ(CLK_FREQ_HZ),
      .BAUD_RATE  (BAUD_RATE)
   ) u_uart (
      .clk_sys (SYS_CLK),
      .rst_b   (SYS_RST),
      .rxd     (UART_RXD),
      .txd     (UART_TXD),
      .rx_data (rx_data),
      .rx_valid(rx_valid),
      .tx_data (tx_buf[79:72]),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready)
   );

   always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
      if (!SYS_RST) state <= HUNT;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         HUNT:     if (rx_valid && is_header(rx_data)) state_nxt = RX_BODY;
         RX_BODY:  if (rx_valid && byte_cnt == 4'd1)  state_nxt = RX_TRAIL;
                   else if (timeout)                   state_nxt = HUNT;
         RX_TRAIL: if (rx_valid)                       state_nxt = trail_ok ? BUS : HUNT;
                   else if (timeout)                   state_nxt = HUNT;
         BUS:      state_nxt = BUS_WAIT;
         BUS_WAIT: state_nxt = TX_RESP;
         TX_RESP:  if (tx_left == 4'd0 && tx_ready)    state_nxt = HUNT;
         default:  state_nxt = HUNT;
      endcase
   end

   always_comb begin
      OPB_WE   = (state == BUS) && (hdr == HDR_WR);
      OPB_RE   = (state == BUS) && (hdr == HDR_RD);
      tx_valid = (state == TX_RESP) && (tx_left != 4'd0);
   end

   always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
      if (!SYS_RST) begin
         pulse_sync <= '0;
         hdr        <= '0;
         body       <= '0;
         byte_cnt   <= '0;
         to_cnt     <= '0;
         tx_buf     <= '0;
         tx_left    <= '0;
         OPB_ADDR   <= '0;
         OPB_DO     <= '0;
      end else begin
         pulse_sync <= {pulse_sync[1:0], PULSE_2KHZ};
         case (state)
            HUNT: begin
               if (rx_valid && is_header(rx_data)) begin
                  hdr      <= rx_data;
                  byte_cnt <= 4'(BODY_LEN);
                  to_cnt   <= TW'(TIMEOUT_TICKS);
               end
            end
            RX_BODY: begin
               if (rx_valid) begin
                  body     <= {body[55:0], rx_data};
                  byte_cnt <= byte_cnt - 4'd1;
                  to_cnt   <= TW'(TIMEOUT_TICKS);
               end else if (pulse_rise) begin
                  to_cnt <= to_cnt - TW'(1);
               end
            end
            RX_TRAIL: begin
               if (rx_valid) begin
                  if (trail_ok) begin
                     OPB_ADDR <= body[63:32];
                     if (hdr == HDR_WR) OPB_DO <= body[31:0];
                  end
               end else if (pulse_rise) begin
                  to_cnt <= to_cnt - TW'(1);
               end
            end
            // Slave returns read data one cycle after the strobe.
            BUS_WAIT: begin
               tx_buf  <= {hdr, body[63:32],
                           (hdr == HDR_RD) ? OPB_DI : body[31:0],
                           trailer_of(hdr)};
               tx_left <= 4'(FRAME_LEN);
            end
            TX_RESP: begin
               if (tx_valid && tx_ready) begin
                  tx_buf  <= {tx_buf[71:0], 8'h00};
                  tx_left <= tx_left - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_server.sv
// Directed bench for cmd_server: write, read, bad trailer, junk resync,
// inter-byte timeout and mid-frame reset.
module tb_cmd_server;

   localparam int CLK_HZ = 100_000_000;
   localparam int BAUD   = 12_500_000;
   localparam int BIT    = CLK_HZ / BAUD;

   logic        SYS_CLK = 1'b0;
   logic        SYS_RST = 1'b0;
   logic        PULSE_2KHZ = 1'b0;
   logic        UART_RXD = 1'b1;
   logic [31:0] OPB_DI = '0;
   logic        OPB_CLK, OPB_RST, OPB_RE, OPB_WE, UART_TXD;
   logic [31:0] OPB_DO, OPB_ADDR;

   cmd_server #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
      .SYS_CLK   (SYS_CLK),
      .SYS_RST   (SYS_RST),
      .PULSE_2KHZ(PULSE_2KHZ),
      .OPB_CLK   (OPB_CLK),
      .OPB_RST   (OPB_RST),
      .OPB_DI    (OPB_DI),
      .OPB_DO    (OPB_DO),
      .OPB_ADDR  (OPB_ADDR),
      .OPB_RE    (OPB_RE),
      .OPB_WE    (OPB_WE),
      .UART_RXD  (UART_RXD),
      .UART_TXD  (UART_TXD)
   );

   always #5 SYS_CLK = ~SYS_CLK;

   int n_chk = 0;
   int n_err = 0;
   int we_cnt = 0, re_cnt = 0, both_cnt = 0;
   logic [31:0] we_addr = '0, we_data = '0, re_addr = '0;
   logic [7:0]  tx_q[$];
   int wb, rb, tb0;

   task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge SYS_CLK) begin
      if (OPB_WE) begin we_cnt++; we_addr = OPB_ADDR; we_data = OPB_DO; end
      if (OPB_RE) begin re_cnt++; re_addr = OPB_ADDR; end
      if (OPB_WE && OPB_RE) both_cnt++;
   end

   initial begin
      forever begin
         logic [7:0] b;
         @(negedge UART_TXD);
         repeat (BIT / 2) @(negedge SYS_CLK);
         for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge SYS_CLK);
            b[i] = UART_TXD;
         end
         repeat (BIT) @(negedge SYS_CLK);
         tx_q.push_back(b);
      end
   end

   task automatic send_byte(input logic [7:0] b);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge SYS_CLK);
         UART_RXD = f[i];
         repeat (BIT - 1) @(negedge SYS_CLK);
      end
   endtask

   task automatic send_frame(input logic [79:0] f);
      for (int i = 0; i < 10; i++) send_byte(f[79 - 8*i -: 8]);
   endtask

   task automatic mark();
      wb  = we_cnt;
      rb  = re_cnt;
      tb0 = tx_q.size();
   endtask

   // Bounded wait for n response bytes, then a quiet window to catch extras.
   task automatic wait_resp(input string tag, input int n);
      int k;
      k = 0;
      while (tx_q.size() < tb0 + n && k < 3000) begin
         @(negedge SYS_CLK);
         k++;
      end
      repeat (200) @(negedge SYS_CLK);
      chk({tag, "_resp_len"}, 80'(tx_q.size() - tb0), 80'(n));
   endtask

   function automatic logic [79:0] resp();
      logic [79:0] r;
      r = '0;
      for (int i = 0; i < 10; i++)
         if (tb0 + i < tx_q.size()) r = {r[71:0], tx_q[tb0 + i]};
      return r;
   endfunction

   task automatic chk_bus(input string tag, input int nwe, input int nre);
      chk({tag, "_we_cnt"}, 80'(we_cnt - wb), 80'(nwe));
      chk({tag, "_re_cnt"}, 80'(re_cnt - rb), 80'(nre));
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (5) @(negedge SYS_CLK);
      chk("rst_addr", 80'(OPB_ADDR), 80'h0);
      chk("rst_do",   80'(OPB_DO),   80'h0);
      chk("rst_re",   80'(OPB_RE),   80'h0);
      chk("rst_we",   80'(OPB_WE),   80'h0);
      chk("rst_txd",  80'(UART_TXD), 80'h1);
      chk("rst_opb_rst", 80'(OPB_RST), 80'h1);
      SYS_RST = 1'b1;
      repeat (5) @(negedge SYS_CLK);
      chk("run_opb_rst", 80'(OPB_RST), 80'h0);

      // Plain write with echo
      mark();
      send_frame(80'h5A_AABBCCDD_11223344_A5);
      wait_resp("wr", 10);
      chk_bus("wr", 1, 0);
      chk("wr_addr", 80'(we_addr), 80'hAABBCCDD);
      chk("wr_data", 80'(we_data), 80'h11223344);
      chk("wr_echo", resp(), 80'h5A_AABBCCDD_11223344_A5);
      chk("wr_addr_hold", 80'(OPB_ADDR), 80'hAABBCCDD);
      chk("wr_do_hold",   80'(OPB_DO),   80'h11223344);

      // Read with 1-cycle latency data
      OPB_DI = 32'h12345678;
      mark();
      send_frame(80'h5B_12345678_AABBCCDD_A4);
      wait_resp("rd", 10);
      chk_bus("rd", 0, 1);
      chk("rd_addr", 80'(re_addr), 80'h12345678);
      chk("rd_resp", resp(), 80'h5B_12345678_12345678_A4);

      // Wrong trailer is silently dropped, next frame works
      mark();
      send_frame(80'h5A_AABBCCDD_11223344_A4);
      wait_resp("badtrl", 0);
      chk_bus("badtrl", 0, 0);
      mark();
      send_frame(80'h5A_01020304_05060708_A5);
      wait_resp("after_bad", 10);
      chk_bus("after_bad", 1, 0);
      chk("after_bad_addr", 80'(we_addr), 80'h01020304);
      chk("after_bad_echo", resp(), 80'h5A_01020304_05060708_A5);

      // Junk bytes ahead of a valid frame
      mark();
      send_byte(8'h00);
      send_byte(8'hFF);
      send_frame(80'h5A_DEADBEEF_CAFEF00D_A5);
      wait_resp("junk", 10);
      chk_bus("junk", 1, 0);
      chk("junk_data", 80'(we_data), 80'hCAFEF00D);
      chk("junk_echo", resp(), 80'h5A_DEADBEEF_CAFEF00D_A5);

      // Stalled partial frame aborted after two timebase edges
      mark();
      send_byte(8'h5A);
      send_byte(8'hAA);
      repeat (2) begin
         PULSE_2KHZ = 1'b1;
         repeat (10) @(negedge SYS_CLK);
         PULSE_2KHZ = 1'b0;
         repeat (10) @(negedge SYS_CLK);
      end
      OPB_DI = 32'hCAFEBABE;
      send_frame(80'h5B_00000010_55667788_A4);
      wait_resp("tmo", 10);
      chk_bus("tmo", 0, 1);
      chk("tmo_addr", 80'(re_addr), 80'h00000010);
      chk("tmo_resp", resp(), 80'h5B_00000010_CAFEBABE_A4);

      // Reset in the middle of the 5th byte
      mark();
      send_byte(8'h5A);
      send_byte(8'h87);
      send_byte(8'h65);
      send_byte(8'h43);
      @(negedge SYS_CLK);
      UART_RXD = 1'b0;
      repeat (2 * BIT) @(negedge SYS_CLK);
      SYS_RST  = 1'b0;
      UART_RXD = 1'b1;
      repeat (2) @(negedge SYS_CLK);
      chk("mid_rst_addr", 80'(OPB_ADDR), 80'h0);
      chk("mid_rst_do",   80'(OPB_DO),   80'h0);
      chk("mid_rst_re",   80'(OPB_RE),   80'h0);
      chk("mid_rst_we",   80'(OPB_WE),   80'h0);
      chk("mid_rst_txd",  80'(UART_TXD), 80'h1);
      repeat (3) @(negedge SYS_CLK);
      SYS_RST = 1'b1;
      repeat (5) @(negedge SYS_CLK);
      send_frame(80'h5A_87654321_0F0F0F0F_A5);
      wait_resp("post_rst", 10);
      chk_bus("post_rst", 1, 0);
      chk("post_rst_addr", 80'(we_addr), 80'h87654321);
      chk("post_rst_data", 80'(we_data), 80'h0F0F0F0F);
      chk("post_rst_echo", resp(), 80'h5A_87654321_0F0F0F0F_A5);

      chk("re_we_overlap", 80'(both_cnt), 80'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/cmd_server.md
CMD_SERVER -- requirements
Module: cmd_server

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100000000, SYS_CLK frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, UART bit rate.
REQ-003 SYS_CLK  input  1  sole clock; all logic on rising edge.
REQ-004 SYS_RST  input  1  asynchronous, active-low reset.
REQ-005 PULSE_2KHZ  input  1  2 kHz timebase for the receive inter-byte timeout; synchronised internally.
REQ-006 OPB_CLK  output  1  equals SYS_CLK.
REQ-007 OPB_RST  output  1  active-high bus reset, equals inverted SYS_RST.
REQ-008 OPB_DI  input  32  read data from the bus slave.
REQ-009 OPB_DO  output  32  write data to the bus slave.
REQ-010 OPB_ADDR  output  32  bus address.
REQ-011 OPB_RE  output  1  one-cycle read strobe.
REQ-012 OPB_WE  output  1  one-cycle write strobe.
REQ-013 UART_RXD  input  1  serial command input, idle high.
REQ-014 UART_TXD  output  1  serial response output, idle high.

Function
REQ-015 UART is 8N1, LSB first, with bit period = CLK_FREQ_HZ/BAUD_RATE truncated (868 clocks at the defaults).
REQ-016 The RX path shall double-flop UART_RXD, detect a start bit on a falling edge, recheck it at mid-bit, and sample data at mid-bit.
REQ-017 An RX byte with a low stop bit shall be dropped.
REQ-018 A command frame is 10 bytes: header, ADDR[31:24..7:0], DATA[31:24..7:0], trailer; multi-byte fields are MSB first.
REQ-019 Header 0x5A means write; header 0x5B means read; trailer shall equal the bitwise inverse of the header (0xA5 or 0xA4).
REQ-020 In the idle state, any byte other than 0x5A or 0x5B shall be discarded and the parser shall stay in HUNT.
REQ-021 FSM states: HUNT, RX_BODY (8 bytes), RX_TRAIL, BUS, BUS_WAIT, TX_RESP (10 bytes), then back to HUNT.
REQ-022 On a wrong trailer, the frame shall be discarded: no bus cycle, no response, return to HUNT.
REQ-023 If a frame is in progress and two PULSE_2KHZ rising edges occur without a new byte, the parser shall abort to HUNT.
REQ-024 Write: in BUS, OPB_ADDR and OPB_DO are driven and OPB_WE is high for exactly 1 cycle.
REQ-025 Read: in BUS, OPB_ADDR is driven and OPB_RE is high for exactly 1 cycle; OPB_DI is captured on the following cycle (1-cycle read latency).
REQ-026 OPB_ADDR and OPB_DO shall hold their values after the strobe until the next command.
REQ-027 Write response: an echo of the 10 received bytes.
REQ-028 Read response: 0x5B, 4 address bytes, 4 captured OPB_DI bytes MSB first, 0xA4.
REQ-029 Response bytes are sent back-to-back with no idle gap beyond the stop bit.
REQ-030 Bytes arriving on UART_RXD during BUS, BUS_WAIT or TX_RESP shall be discarded.
REQ-031 OPB_RE and OPB_WE shall never be high in the same cycle.

Reset
REQ-032 While SYS_RST is low: the FSM is in HUNT; OPB_ADDR=0, OPB_DO=0, OPB_RE=0, OPB_WE=0, UART_TXD=1; the timeout counter and byte counters are cleared.
REQ-033 Reset asserted mid-frame or mid-transmit shall abort immediately; after release, UART_TXD is idle high and no partial frame is resumed.

Structure
REQ-034 Package cmd_server_pkg shall hold the header and trailer constants (0x5A, 0x5B, 0xA5, 0xA4), the frame length of 10, the FSM state typedef and the timeout tick count of 2.
REQ-035 One sub-module, cmd_uart (byte-level RX/TX with valid/ready handshakes, parameterised by CLK_FREQ_HZ and BAUD_RATE); the frame FSM and OPB logic live in cmd_server.

Verification
REQ-036 Write: send 5A AA BB CC DD 11 22 33 44 A5 -> one-cycle OPB_WE with ADDR=AABBCCDD and DO=11223344; response echoes the 10 bytes.
REQ-037 Read: set OPB_DI=12345678, send 5B 12 34 56 78 AA BB CC DD A4 -> one-cycle OPB_RE with ADDR=12345678; response 5B 12 34 56 78 12 34 56 78 A4.
REQ-038 Bad trailer: send a write frame ending in 0xA4 -> no OPB_WE, no TX activity; a following valid frame is processed normally.
REQ-039 Junk resync: send 00 FF then a valid write frame -> exactly one write, correct echo.
REQ-040 Timeout: send 5A AA, wait >1 ms, then send a full valid read frame -> exactly one read, correct response.
REQ-041 Reset: assert SYS_RST low during the 5th byte -> all outputs at reset values, UART_TXD high; a subsequent full frame completes correctly.
